// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic GEMM engine.
//   gemm_state_t : job sequencer states
//   DEF_*        : default build parameters
//   clog2_min1   : ceil(log2(n)) but never below 1, for index/counter widths
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } gemm_state_t;

    localparam int unsigned DEF_ROWS = 4;
    localparam int unsigned DEF_COLS = 4;
    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_AW   = 32;
    localparam int unsigned DEF_KW   = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/systolic_gemm_mac_pe.sv
// One processing element of the output-stationary array.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the accumulator (overrides the MAC this cycle)
//   a_in/b_in: operands arriving from the left / from above
//   a_out    : a_in delayed one cycle, to the right-hand neighbour
//   b_out    : b_in delayed one cycle, to the neighbour below
//   acc      : running sum of sext(a)*sext(b), wraps modulo 2^AW
module mac_pe #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);

    logic signed [DW-1:0]   a_q, b_q;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod  = a_in * b_in;
        acc_d = clear ? '0 : acc_q + AW'(prod);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_gemm.sv
// Self-sequencing output-stationary systolic GEMM: C = A*B (+ previous C).
//   clk, rst          : clock, synchronous active-high reset
//   start, k_len,
//   accumulate        : job launch (IDLE only), K length, keep-C flag
//   busy, done        : job in progress, one-cycle completion pulse
//   in_valid/in_ready : K-beat operand stream, a_col = column k of A, b_row = row k of B
//   out_valid/out_ready, out_row_idx, out_data : row-serial result drain
module systolic_gemm import systolic_pkg::*; #(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned AW   = DEF_AW,
    parameter int unsigned KW   = DEF_KW
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [KW-1:0]                    k_len,
    input  logic                             accumulate,
    output logic                             busy,
    output logic                             done,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ROWS*DW-1:0]               a_col,
    input  logic [COLS*DW-1:0]               b_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [clog2_min1(ROWS)-1:0]      out_row_idx,
    output logic [COLS*AW-1:0]               out_data
);

    localparam int unsigned RIW       = clog2_min1(ROWS);
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
    localparam int unsigned FW        = clog2_min1(FLUSH_LEN);

    gemm_state_t    state_q, state_d;
    logic [KW-1:0]  k_q, k_d, beat_q, beat_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic [RIW-1:0] row_q, row_d;
    logic           done_q, done_d;
    logic           clear_acc;
    logic           beat;

    assign in_ready = (state_q == LOAD);
    assign beat     = in_valid && in_ready;

    // Sequencer and counters
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        beat_d    = beat_q;
        flush_d   = '0;
        row_d     = row_q;
        done_d    = 1'b0;
        clear_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k_d       = k_len;
                    beat_d    = '0;
                    row_d     = '0;
                    clear_acc = !accumulate;
                    state_d   = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_q - KW'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Long enough for the last beat to reach PE(ROWS-1,COLS-1)
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(FLUSH_LEN - 1)) begin
                    flush_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (row_q == RIW'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + RIW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign out_valid   = (state_q == DRAIN);
    assign out_row_idx = row_q;

    // Operand injection: non-beat cycles feed zeros so the array never stalls
    logic signed [DW-1:0] a_inj [ROWS];
    logic signed [DW-1:0] b_inj [COLS];
    always_comb begin
        for (int i = 0; i < ROWS; i++) a_inj[i] = beat ? a_col[i*DW +: DW] : '0;
        for (int j = 0; j < COLS; j++) b_inj[j] = beat ? b_row[j*DW +: DW] : '0;
    end

    // a_h[i][j] enters PE(i,j) from the left; b_v[i][j] enters PE(i,j) from above
    logic signed [DW-1:0] a_h [ROWS][COLS+1];
    logic signed [DW-1:0] b_v [ROWS+1][COLS];
    logic signed [AW-1:0] acc [ROWS][COLS];

    // Row i is delayed i cycles so that beat k meets its B partner at every PE
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_h[i][0] = a_inj[i];
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < i; s++) sr_q[s] <= '0;
                end else begin
                    sr_q[0] <= a_inj[i];
                    for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign a_h[i][0] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_v[0][j] = b_inj[j];
        end else begin : g_delay
            logic signed [DW-1:0] sr_q [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < j; s++) sr_q[s] <= '0;
                end else begin
                    sr_q[0] <= b_inj[j];
                    for (int s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
                end
            end
            assign b_v[0][j] = sr_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            mac_pe #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clear (clear_acc),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc[i][j])
            );
        end
    end

    // Operands leaving the array edges have no consumer
    logic unused_edges;
    always_comb begin
        unused_edges = 1'b0;
        for (int i = 0; i < ROWS; i++) unused_edges = unused_edges ^ (^a_h[i][COLS]);
        for (int j = 0; j < COLS; j++) unused_edges = unused_edges ^ (^b_v[ROWS][j]);
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++) out_data[j*AW +: AW] = acc[row_q][j];
    end

endmodule

// File: tb/tb_systolic_gemm.sv
// Self-checking bench for systolic_gemm against a plain matrix-multiply model.
module tb_systolic_gemm;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KW   = 16;
    localparam int KMAX = 8;

    logic                 clk = 1'b0;
    logic                 rst, start, accumulate, in_valid, out_ready;
    logic [KW-1:0]        k_len;
    logic [ROWS*DW-1:0]   a_col;
    logic [COLS*DW-1:0]   b_row;
    logic                 busy, done, in_ready, out_valid;
    logic [1:0]           out_row_idx;
    logic [COLS*AW-1:0]   out_data;

    systolic_gemm #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .accumulate  (accumulate),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_col       (a_col),
        .b_row       (b_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_idx (out_row_idx),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] a_m   [ROWS][KMAX];
    logic signed [DW-1:0] b_m   [KMAX][COLS];
    logic signed [AW-1:0] m_acc [ROWS][COLS];
    logic        [AW-1:0] res   [ROWS][COLS];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // C (+)= A*B computed directly from the matrices
    task automatic model_job(input int k, input bit acc);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                if (!acc) m_acc[i][j] = '0;
                for (int kk = 0; kk < k; kk++)
                    m_acc[i][j] = m_acc[i][j] + a_m[i][kk] * b_m[kk][j];
            end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) m_acc[i][j] = '0;
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) a_m[i][k] = DW'(av);
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) b_m[k][j] = DW'(bv);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) a_m[i][k] = DW'($urandom);
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) b_m[k][j] = DW'($urandom);
    endtask

    // Runs one job; latencies are in cycles relative to the start cycle.
    task automatic run_job(input int k, input bit acc, input bit bubbles,
                           input int stall_row, input int stall_len, input bit poke_start,
                           output int lat_valid, output int lat_done, output int last_beat,
                           output bit idx_ok, output bit stable_ok);
        int t0, sent, row, stalled, budget;
        bit tog, took;
        logic [COLS*AW-1:0] snap;
        logic [1:0]         snap_idx;
        lat_valid = -1; lat_done = -1; last_beat = -1; idx_ok = 1; stable_ok = 1;
        snap = '0; snap_idx = '0;
        start = 1'b1; k_len = KW'(k); accumulate = acc; t0 = cyc;
        step();
        start = 1'b0; accumulate = 1'b0;
        sent = 0; tog = 1'b1; budget = 0;
        while (sent < k && budget < 1000) begin
            in_valid = bubbles ? tog : 1'b1;
            tog = !tog;
            a_col = ROWS*DW'({$urandom, $urandom});
            b_row = COLS*DW'({$urandom, $urandom});
            if (in_valid) begin
                for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = a_m[i][sent];
                for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = b_m[sent][j];
            end
            took = in_valid && in_ready;
            if (took) last_beat = cyc - t0;
            step();
            if (took) sent++;
            budget++;
        end
        in_valid = 1'b0;
        row = 0; stalled = 0; budget = 0;
        while (row < ROWS && budget < 1000) begin
            if (out_valid && lat_valid < 0) lat_valid = cyc - t0;
            out_ready = 1'b1;
            if (out_valid) begin
                if (row == stall_row && stalled < stall_len) begin
                    if (stalled == 0) begin
                        snap = out_data; snap_idx = out_row_idx;
                    end else if (out_data !== snap || out_row_idx !== snap_idx) begin
                        stable_ok = 0;
                    end
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    if (stalled > 0 && row == stall_row &&
                        (out_data !== snap || out_row_idx !== snap_idx)) stable_ok = 0;
                    if (out_row_idx !== 2'(row)) idx_ok = 0;
                    for (int j = 0; j < COLS; j++) res[row][j] = out_data[j*AW +: AW];
                    row++;
                end
            end
            start = poke_start && (row == 1);
            k_len = KW'(3);
            step();
            budget++;
        end
        start = 1'b0; out_ready = 1'b1;
        if (row < ROWS) begin
            checks++; errors++;
            $display("FAIL job_timeout: drained %0d rows, required %0d", row, ROWS);
        end
        if (done) lat_done = cyc - t0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0; accumulate = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; a_col = '0; b_row = '0;
        repeat (3) step();
        rst = 1'b0;
        model_clear();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_row_idx !== 2'd0) begin errors++;
            $display("FAIL reset_row_idx: got %0d required 0", out_row_idx); end
        checks++; if (out_data !== '0) begin errors++;
            $display("FAIL reset_out_data: got %h required 0", out_data); end
    endtask

    task automatic test_identity();
        int lv, ld, lb; bit iok, sok;
        for (int i = 0; i < ROWS; i++)
            for (int k = 0; k < KMAX; k++) a_m[i][k] = (i == k) ? DW'(1) : DW'(0);
        for (int k = 0; k < KMAX; k++)
            for (int j = 0; j < COLS; j++) b_m[k][j] = DW'(4 * k + j);
        run_job(4, 0, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(4, 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== AW'(4 * i + j)) begin errors++;
                    $display("FAIL identity_c[%0d][%0d]: got %0d required %0d",
                             i, j, res[i][j], 4 * i + j); end
            end
        checks++; if (lv != 1 + 4 + ROWS + COLS - 1) begin errors++;
            $display("FAIL identity_valid_latency: got %0d required %0d", lv, 12); end
        checks++; if (ld != 1 + 4 + ROWS + COLS - 1 + ROWS) begin errors++;
            $display("FAIL identity_done_latency: got %0d required %0d", ld, 16); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL identity_busy_at_done: got %b required 0", busy); end
        checks++; if (!iok) begin errors++;
            $display("FAIL identity_row_idx: got out-of-order required 0..3"); end
    endtask

    task automatic test_signed();
        int lv, ld, lb; bit iok, sok;
        fill_const(-128, -128);
        run_job(1, 0, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(1, 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== AW'(16384)) begin errors++;
                    $display("FAIL signed_c[%0d][%0d]: got %0d required 16384",
                             i, j, $signed(res[i][j])); end
            end
    endtask

    task automatic test_accumulate();
        int lv, ld, lb; bit iok, sok;
        int exp_v [3];
        int kv [3];
        bit av [3];
        exp_v = '{2, 5, 1}; kv = '{2, 3, 1}; av = '{1'b0, 1'b1, 1'b0};
        fill_const(1, 1);
        for (int n = 0; n < 3; n++) begin
            run_job(kv[n], av[n], 0, -1, 0, 0, lv, ld, lb, iok, sok);
            model_job(kv[n], av[n]);
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    checks++;
                    if (res[i][j] !== AW'(exp_v[n])) begin errors++;
                        $display("FAIL accumulate_job%0d_c[%0d][%0d]: got %0d required %0d",
                                 n, i, j, res[i][j], exp_v[n]); end
                end
        end
    endtask

    task automatic test_bubbles_backpressure();
        int lv, ld, lb; bit iok, sok;
        fill_rand();
        run_job(4, 0, 1, 1, 3, 0, lv, ld, lb, iok, sok);
        model_job(4, 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== m_acc[i][j]) begin errors++;
                    $display("FAIL bubble_c[%0d][%0d]: got %0d required %0d",
                             i, j, $signed(res[i][j]), m_acc[i][j]); end
            end
        checks++; if (lv != lb + ROWS + COLS) begin errors++;
            $display("FAIL bubble_valid_latency: got %0d required %0d", lv, lb + ROWS + COLS); end
        checks++; if (ld != lv + ROWS + 3) begin errors++;
            $display("FAIL bubble_done_latency: got %0d required %0d", ld, lv + ROWS + 3); end
        checks++; if (!sok) begin errors++;
            $display("FAIL stall_stable: got changing row 1 required stable"); end
        checks++; if (!iok) begin errors++;
            $display("FAIL bubble_row_idx: got out-of-order required 0..3"); end
    endtask

    task automatic test_kzero();
        int lv, ld, lb; bit iok, sok;
        fill_rand();
        run_job(3, 0, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(3, 0);
        run_job(0, 0, 0, -1, 0, 1, lv, ld, lb, iok, sok);
        model_job(0, 0);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== '0) begin errors++;
                    $display("FAIL kzero_clear_c[%0d][%0d]: got %0d required 0",
                             i, j, res[i][j]); end
            end
        checks++; if (lv != 1) begin errors++;
            $display("FAIL kzero_valid_latency: got %0d required 1", lv); end
        checks++; if (ld != 1 + ROWS) begin errors++;
            $display("FAIL kzero_done_latency: got %0d required %0d", ld, 1 + ROWS); end
        step();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL drain_start_ignored: got busy=%b required 0", busy); end
        fill_rand();
        run_job(2, 0, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(2, 0);
        run_job(0, 1, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(0, 1);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== m_acc[i][j]) begin errors++;
                    $display("FAIL kzero_retain_c[%0d][%0d]: got %0d required %0d",
                             i, j, $signed(res[i][j]), m_acc[i][j]); end
            end
    endtask

    task automatic test_reset_flush();
        int lv, ld, lb; bit iok, sok;
        fill_const(1, 1);
        start = 1'b1; k_len = KW'(2); accumulate = 1'b0;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < ROWS; i++) a_col[i*DW +: DW] = DW'(1);
        for (int j = 0; j < COLS; j++) b_row[j*DW +: DW] = DW'(1);
        repeat (2) step();
        in_valid = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL flush_midjob: got busy=%b in_ready=%b required 1/0", busy, in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL flush_reset_busy: got %b required 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL flush_reset_out_valid: got %b required 0", out_valid); end
        run_job(1, 1, 0, -1, 0, 0, lv, ld, lb, iok, sok);
        model_job(1, 1);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                checks++;
                if (res[i][j] !== AW'(1)) begin errors++;
                    $display("FAIL flush_reset_c[%0d][%0d]: got %0d required 1",
                             i, j, res[i][j]); end
            end
    endtask

    task automatic test_back_to_back();
        int lv, ld, lb, k, srow, slen; bit acc, bub, iok, sok;
        for (int n = 0; n < 6; n++) begin
            fill_rand();
            k    = $urandom_range(1, KMAX);
            acc  = 1'($urandom_range(0, 1));
            bub  = 1'($urandom_range(0, 1));
            srow = $urandom_range(0, ROWS - 1);
            slen = $urandom_range(0, 3);
            run_job(k, acc, bub, srow, slen, 0, lv, ld, lb, iok, sok);
            model_job(k, acc);
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    checks++;
                    if (res[i][j] !== m_acc[i][j]) begin errors++;
                        $display("FAIL rand%0d_c[%0d][%0d]: got %0d required %0d",
                                 n, i, j, $signed(res[i][j]), m_acc[i][j]); end
                end
            checks++; if (lv != lb + ROWS + COLS) begin errors++;
                $display("FAIL rand%0d_valid_latency: got %0d required %0d",
                         n, lv, lb + ROWS + COLS); end
            checks++; if (ld != lv + ROWS + slen) begin errors++;
                $display("FAIL rand%0d_done_latency: got %0d required %0d",
                         n, ld, lv + ROWS + slen); end
            checks++; if (!iok || !sok) begin errors++;
                $display("FAIL rand%0d_drain: got idx_ok=%0b stable_ok=%0b required 1/1",
                         n, iok, sok); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_accumulate();
        test_bubbles_backpressure();
        test_kzero();
        test_reset_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
